timer_mux: RTL and testbench

Free-running one-second display-select sequencer. It divides the system clock down to a 1 Hz square wave, as the former `timer1seg` did, and rotates a 4-bit one-hot select word, as the former `mux` did, by one position per period. It sits between the board clock and the 4-digit display driver, whose digit anodes take `saida`. Everything runs in the single `clk` domain: the divided clock is an output only and never clocks logic.

---
 rtl/timer_mux.sv | 64 ++++++
 tb/tb_timer_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/timer_mux.sv
// One-second display-select sequencer: clock divider plus rotating one-hot select.
// Optional `hold` input enabled by defining TIMER_MUX_HOLD_EN.
module timer_mux #(
    parameter int unsigned HALF_COUNT = 25_000_000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TIMER_MUX_HOLD_EN
    input  logic       hold,
`endif
    output logic       clk_out,
    output logic       tick,
    output logic [3:0] saida,
    output logic [1:0] sel
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [3:0]       saida_q, saida_d;
    logic [1:0]       sel_q, sel_d;
    logic             wrap, step_en;

`ifdef TIMER_MUX_HOLD_EN
    assign step_en = ~hold;
`else
    assign step_en = 1'b1;
`endif

    always_comb begin
        wrap      = (cnt_q == LAST);
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        clk_out_d = wrap ? ~clk_out_q : clk_out_q;
        // Advance only on the rising toggle of the divided clock.
        tick_d    = wrap & ~clk_out_q & step_en;
        saida_d   = tick_d ? {saida_q[2:0], saida_q[3]} : saida_q;
        sel_d     = tick_d ? sel_q + 2'd1 : sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            saida_q   <= 4'b0001;
            sel_q     <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            saida_q   <= saida_d;
            sel_q     <= sel_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign saida   = saida_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_timer_mux.sv
// Bench for timer_mux: HALF_COUNT=2 and HALF_COUNT=1 instances against an edge-count model.
module tb_timer_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_m = 1'b0;

    logic       co_a, tk_a, co_b, tk_b;
    logic [3:0] sa_a, sa_b;
    logic [1:0] se_a, se_b;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release and number of accepted advances.
    int n_a = 0, adv_a = 0, n_b = 0, adv_b = 0;
    logic tk_a_e = 1'b0, tk_b_e = 1'b0;

    timer_mux #(.HALF_COUNT(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst),
`ifdef TIMER_MUX_HOLD_EN
        .hold(hold_m),
`endif
        .clk_out(co_a), .tick(tk_a), .saida(sa_a), .sel(se_a)
    );

    timer_mux #(.HALF_COUNT(1), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst),
`ifdef TIMER_MUX_HOLD_EN
        .hold(hold_m),
`endif
        .clk_out(co_b), .tick(tk_b), .saida(sa_b), .sel(se_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_clk_out", 32'(co_a), 32'((n_a / 2) % 2));
        check("a_tick",    32'(tk_a), 32'(tk_a_e));
        check("a_saida",   32'(sa_a), 32'(1 << (adv_a % 4)));
        check("a_sel",     32'(se_a), 32'(adv_a % 4));
        check("b_clk_out", 32'(co_b), 32'(n_b % 2));
        check("b_tick",    32'(tk_b), 32'(tk_b_e));
        check("b_saida",   32'(sa_b), 32'(1 << (adv_b % 4)));
        check("b_sel",     32'(se_b), 32'(adv_b % 4));
        check("b_onehot",  32'($onehot(sa_b)), 32'd1);
    endtask

    task automatic model_reset();
        n_a = 0; adv_a = 0; tk_a_e = 1'b0;
        n_b = 0; adv_b = 0; tk_b_e = 1'b0;
    endtask

    // One clock edge, then compare at the following falling edge.
    task automatic edge_step();
        @(posedge clk);
        n_a++;
        tk_a_e = (n_a % 4 == 2) && !hold_m;
        if (tk_a_e) adv_a++;
        n_b++;
        tk_b_e = (n_b % 2 == 1) && !hold_m;
        if (tk_b_e) adv_b++;
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse inside the low phase of clk.
    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        check("rst_saida",   32'(sa_a), 32'h1);
        check("rst_sel",     32'(se_a), 32'h0);
        check("rst_clk_out", 32'(co_a), 32'h0);
        check("rst_tick",    32'(tk_a), 32'h0);
        check("rst_b_saida", 32'(sa_b), 32'h1);
        #1 rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] rot_tbl [4];

    initial begin
        rot_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Power-up reset, released before edge 1.
        @(negedge clk);
        check_all();
        rst = 1'b0;
        model_reset();

        // Divider and full rotation over 16 edges.
        for (int i = 0; i < 16; i++) begin
            edge_step();
            if (n_a % 4 == 2) begin
                check("rot_saida", 32'(sa_a), 32'(rot_tbl[(n_a - 2) / 4]));
                check("rot_tick",  32'(tk_a), 32'd1);
            end
            if (n_a % 4 == 0) check("fall_clk_out", 32'(co_a), 32'd0);
        end

        // Reset mid-operation with saida=0100 and cnt=1 (after edge 7).
        reset_pulse();
        for (int i = 0; i < 7; i++) edge_step();
        check("pre_rst_saida", 32'(sa_a), 32'h4);
        reset_pulse();
        edge_step();
        check("post_rst_e1", 32'(sa_a), 32'h1);
        edge_step();
        check("post_rst_e2", 32'(sa_a), 32'h2);
        check("post_rst_tick", 32'(tk_a), 32'd1);

`ifdef TIMER_MUX_HOLD_EN
        // Hold across edges 6 and 10, release before 14.
        reset_pulse();
        for (int i = 0; i < 4; i++) edge_step();
        hold_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            edge_step();
            check("hold_saida", 32'(sa_a), 32'h2);
            check("hold_tick",  32'(tk_a), 32'd0);
        end
        hold_m = 1'b0;
        for (int i = 0; i < 2; i++) edge_step();
        check("hold_release", 32'(sa_a), 32'h4);
`endif

        // Randomized run with sporadic reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) reset_pulse();
`ifdef TIMER_MUX_HOLD_EN
            hold_m = ($urandom_range(0, 3) == 0);
`endif
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
